// File: rtl/bp_be_wb_port_arbiter_if.sv
// Writeback bus between the issue pipes / long-latency unit and the regfile
// write-port arbiter. The slave modport is the arbiter; the master modport is the producer side.
interface bp_be_wb_port_arbiter_if #(
    parameter int data_width_p     = 64,
    parameter int reg_addr_width_p = 5,
    parameter int lq_els_p         = 4
) ();
    logic                                    pipe0_v_i;
    logic [reg_addr_width_p-1:0]             pipe0_addr_i;
    logic [data_width_p-1:0]                 pipe0_data_i;
    logic                                    pipe1_v_i;
    logic [reg_addr_width_p-1:0]             pipe1_addr_i;
    logic [data_width_p-1:0]                 pipe1_data_i;
    logic                                    long_v_i;
    logic [reg_addr_width_p-1:0]             long_addr_i;
    logic [data_width_p-1:0]                 long_data_i;
    logic                                    long_ready_o;
    logic [1:0]                              rd_w_v_o;
    logic [1:0][reg_addr_width_p-1:0]        rd_addr_o;
    logic [1:0][data_width_p-1:0]            rd_data_o;
    logic [$clog2(lq_els_p+1)-1:0]           lq_count_o;

    modport slave (
        input  pipe0_v_i, pipe0_addr_i, pipe0_data_i,
        input  pipe1_v_i, pipe1_addr_i, pipe1_data_i,
        input  long_v_i, long_addr_i, long_data_i,
        output long_ready_o, rd_w_v_o, rd_addr_o, rd_data_o, lq_count_o
    );

    modport master (
        output pipe0_v_i, pipe0_addr_i, pipe0_data_i,
        output pipe1_v_i, pipe1_addr_i, pipe1_data_i,
        output long_v_i, long_addr_i, long_data_i,
        input  long_ready_o, rd_w_v_o, rd_addr_o, rd_data_o, lq_count_o
    );
endinterface

// File: rtl/bp_be_wb_port_arbiter.sv
// Merges two issue-slot writebacks and a queued long-latency source onto two regfile write ports.
// Optional same-cycle long-result bypass when BP_BE_WB_ARB_BYPASS_EN is defined.
module bp_be_wb_port_arbiter #(
    parameter int data_width_p     = 64,
    parameter int reg_addr_width_p = 5,
    parameter int lq_els_p         = 4,
    parameter int zero_x0_p        = 1
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    bp_be_wb_port_arbiter_if.slave   wb
);
    localparam int cnt_w_lp = $clog2(lq_els_p+1);
    localparam int ptr_w_lp = $clog2(lq_els_p);
    localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(lq_els_p);

    typedef logic [reg_addr_width_p-1:0] addr_t;
    typedef logic [data_width_p-1:0]     data_t;

    addr_t                mem_addr [lq_els_p];
    data_t                mem_data [lq_els_p];
    logic [cnt_w_lp-1:0]  count, count_next;
    logic [ptr_w_lp-1:0]  rptr, wptr, nptr;

    logic   p0_act, p1_act, long_ready, enq, byp;
    logic   drain_h, drain_n;
    addr_t  head_addr, next_addr;
    data_t  head_data, next_data;
    logic [1:0]       rd_v;
    logic [1:0][reg_addr_width_p-1:0] rd_addr;
    logic [1:0][data_width_p-1:0]     rd_data;

    function automatic logic is_x0(input addr_t a);
        return (zero_x0_p != 0) && (a == '0);
    endfunction

    function automatic logic pipe_hit(input addr_t a, input logic v0, input addr_t a0,
                                      input logic v1, input addr_t a1);
        return (v0 && (a == a0)) || (v1 && (a == a1));
    endfunction

    always_comb begin
        // Older slot yields to the younger one on a same-address collision.
        p1_act = wb.pipe1_v_i && !is_x0(wb.pipe1_addr_i);
        p0_act = wb.pipe0_v_i && !is_x0(wb.pipe0_addr_i)
                 && !(wb.pipe1_v_i && (wb.pipe0_addr_i == wb.pipe1_addr_i));

        nptr      = rptr + 1'b1;
        head_addr = mem_addr[rptr];
        head_data = mem_data[rptr];
        next_addr = mem_addr[nptr];
        next_data = mem_data[nptr];

        long_ready = reset_n_i && (count < full_lp);

        drain_h = (count != '0) && !(p0_act && p1_act)
                  && !pipe_hit(head_addr, p0_act, wb.pipe0_addr_i, p1_act, wb.pipe1_addr_i);
        // head+1 only with both ports free, never alongside a same-address head.
        drain_n = drain_h && !p0_act && !p1_act && (count > cnt_w_lp'(1))
                  && (next_addr != head_addr);

`ifdef BP_BE_WB_ARB_BYPASS_EN
        byp = (count == '0) && wb.long_v_i && long_ready && !is_x0(wb.long_addr_i)
              && !(p0_act && p1_act)
              && !pipe_hit(wb.long_addr_i, p0_act, wb.pipe0_addr_i, p1_act, wb.pipe1_addr_i);
`else
        byp = 1'b0;
`endif

        enq = wb.long_v_i && long_ready && !is_x0(wb.long_addr_i) && !byp;

        count_next = count + cnt_w_lp'(enq) - cnt_w_lp'(drain_h) - cnt_w_lp'(drain_n);
    end

    always_comb begin
        rd_v    = '0;
        rd_addr = '0;
        rd_data = '0;

        if (p0_act) begin
            rd_v[0]    = 1'b1;
            rd_addr[0] = wb.pipe0_addr_i;
            rd_data[0] = wb.pipe0_data_i;
        end else if (drain_h) begin
            rd_v[0]    = 1'b1;
            rd_addr[0] = head_addr;
            rd_data[0] = head_data;
        end else if (byp) begin
            rd_v[0]    = 1'b1;
            rd_addr[0] = wb.long_addr_i;
            rd_data[0] = wb.long_data_i;
        end

        if (p1_act) begin
            rd_v[1]    = 1'b1;
            rd_addr[1] = wb.pipe1_addr_i;
            rd_data[1] = wb.pipe1_data_i;
        end else if (drain_h && p0_act) begin
            rd_v[1]    = 1'b1;
            rd_addr[1] = head_addr;
            rd_data[1] = head_data;
        end else if (drain_n) begin
            rd_v[1]    = 1'b1;
            rd_addr[1] = next_addr;
            rd_data[1] = next_data;
        end else if (byp && p0_act) begin
            rd_v[1]    = 1'b1;
            rd_addr[1] = wb.long_addr_i;
            rd_data[1] = wb.long_data_i;
        end

        // Reset forces the combinational pass-through quiet as well.
        if (!reset_n_i) begin
            rd_v    = '0;
            rd_addr = '0;
            rd_data = '0;
        end
    end

    assign wb.rd_w_v_o     = rd_v;
    assign wb.rd_addr_o    = rd_addr;
    assign wb.rd_data_o    = rd_data;
    assign wb.long_ready_o = long_ready;
    assign wb.lq_count_o   = count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            count <= count_next;
            rptr  <= rptr + ptr_w_lp'(drain_h) + ptr_w_lp'(drain_n);
            if (enq)
                wptr <= wptr + 1'b1;
        end
    end

    // Queue storage is intentionally left out of reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_addr[wptr] <= wb.long_addr_i;
            mem_data[wptr] <= wb.long_data_i;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(enq && (count == full_lp)))
                else $error("long-latency enqueue while queue full");
            assert (!((rd_v == 2'b11) && (rd_addr[0] == rd_addr[1])))
                else $error("both write ports target the same register");
        end
    end
`endif
endmodule

// File: tb/tb_bp_be_wb_port_arbiter.sv
// Scoreboard bench for bp_be_wb_port_arbiter: pipe writes checked per cycle,
// long-latency writes checked in order against an expected-write queue.
module tb_bp_be_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   nl;

`ifdef BP_BE_WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;
    wr_t lq_exp[$];

    always #5 clk = ~clk;

    bp_be_wb_port_arbiter_if #(.data_width_p(64), .reg_addr_width_p(5), .lq_els_p(4)) wb ();

    bp_be_wb_port_arbiter #(
        .data_width_p(64), .reg_addr_width_p(5), .lq_els_p(4), .zero_x0_p(1)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .wb        (wb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus; pv marks ports that must carry the pipe write.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                        input logic lv, input logic [4:0] la, input logic [63:0] ld,
                        input logic [1:0] pv, output int n_long);
        wr_t e;
        wb.pipe0_v_i = v0; wb.pipe0_addr_i = a0; wb.pipe0_data_i = d0;
        wb.pipe1_v_i = v1; wb.pipe1_addr_i = a1; wb.pipe1_data_i = d1;
        wb.long_v_i  = lv; wb.long_addr_i  = la; wb.long_data_i  = ld;
        if (lv && la != 5'd0)
            lq_exp.push_back('{la, ld});
        @(negedge clk);
        n_long = 0;
        for (int p = 0; p < 2; p++) begin
            if (pv[p]) begin
                chk($sformatf("pipe%0d_v", p), 64'(wb.rd_w_v_o[p]), 64'd1);
                chk($sformatf("pipe%0d_addr", p), 64'(wb.rd_addr_o[p]), 64'(p == 0 ? a0 : a1));
                chk($sformatf("pipe%0d_data", p), wb.rd_data_o[p], (p == 0) ? d0 : d1);
            end else if (wb.rd_w_v_o[p]) begin
                n_long++;
                if (lq_exp.size() == 0) begin
                    chk($sformatf("spurious_wr_p%0d", p), 64'(wb.rd_w_v_o[p]), 64'd0);
                end else begin
                    e = lq_exp.pop_front();
                    chk($sformatf("long_addr_p%0d", p), 64'(wb.rd_addr_o[p]), 64'(e.addr));
                    chk($sformatf("long_data_p%0d", p), wb.rd_data_o[p], e.data);
                end
            end
        end
        @(posedge clk);
        #1;
        wb.pipe0_v_i = 1'b0; wb.pipe1_v_i = 1'b0; wb.long_v_i = 1'b0;
    endtask

    task automatic idle(output int n_long);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, n_long);
    endtask

    task automatic enq_busy(input logic [4:0] la, input logic [63:0] ld);
        int n;
        step(1, 5'd20, 64'h20, 1, 5'd21, 64'h21, 1, la, ld, 2'b11, n);
        chk("enq_busy_nl", 64'(n), 64'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rd_v"}, 64'(wb.rd_w_v_o), 64'd0);
        chk({tag, "_rd_addr0"}, 64'(wb.rd_addr_o[0]), 64'd0);
        chk({tag, "_rd_data0"}, wb.rd_data_o[0], 64'd0);
        chk({tag, "_ready"}, 64'(wb.long_ready_o), 64'd0);
        chk({tag, "_count"}, 64'(wb.lq_count_o), 64'd0);
    endtask

    initial begin
        wb.pipe0_v_i = 0; wb.pipe0_addr_i = 0; wb.pipe0_data_i = 0;
        wb.pipe1_v_i = 0; wb.pipe1_addr_i = 0; wb.pipe1_data_i = 0;
        wb.long_v_i  = 0; wb.long_addr_i  = 0; wb.long_data_i  = 0;

        // Reset with a pipe write present: outputs must stay quiet.
        repeat (2) @(posedge clk);
        #1;
        wb.pipe0_v_i = 1; wb.pipe0_addr_i = 5'd3; wb.pipe0_data_i = 64'hAA;
        @(negedge clk);
        reset_checks("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wb.pipe0_v_i = 0;
        #1;
        chk("post_rst_ready", 64'(wb.long_ready_o), 64'd1);
        @(posedge clk);
        #1;

        step(1, 5'd3, 64'hAA, 1, 5'd7, 64'hBB, 0, 0, 0, 2'b11, nl);
        chk("pass_nl", 64'(nl), 64'd0);

        // Collision: younger slot wins, port 0 must stay idle.
        step(1, 5'd5, 64'h1, 1, 5'd5, 64'h2, 0, 0, 0, 2'b10, nl);
        chk("coll_nl", 64'(nl), 64'd0);
        step(1, 5'd0, 64'h9, 0, 0, 0, 0, 0, 0, 2'b00, nl);
        chk("x0_pipe_nl", 64'(nl), 64'd0);

        // Fill queue with both pipes busy, then dual drain.
        for (int i = 0; i < 4; i++)
            enq_busy(5'(10 + i), 64'h100 + 64'(i));
        chk("full_count", 64'(wb.lq_count_o), 64'd4);
        chk("full_ready", 64'(wb.long_ready_o), 64'd0);
        idle(nl);
        chk("drain1_nl", 64'(nl), 64'd2);
        chk("drain1_count", 64'(wb.lq_count_o), 64'd2);
        idle(nl);
        chk("drain2_nl", 64'(nl), 64'd2);
        chk("drain2_count", 64'(wb.lq_count_o), 64'd0);

        // Head held by a same-address pipe write, released next cycle.
        enq_busy(5'd9, 64'h99);
        step(0, 0, 0, 1, 5'd9, 64'h77, 0, 0, 0, 2'b10, nl);
        chk("hold_nl", 64'(nl), 64'd0);
        chk("hold_count", 64'(wb.lq_count_o), 64'd1);
        step(0, 0, 0, 1, 5'd4, 64'h44, 0, 0, 0, 2'b10, nl);
        chk("release_nl", 64'(nl), 64'd1);
        chk("release_count", 64'(wb.lq_count_o), 64'd0);

        // Head goes to port 1 when pipe0 occupies port 0.
        enq_busy(5'd8, 64'h88);
        step(1, 5'd3, 64'h33, 0, 0, 0, 0, 0, 0, 2'b01, nl);
        chk("port1_drain_nl", 64'(nl), 64'd1);

        // Two queued writes to one register drain one per cycle.
        enq_busy(5'd6, 64'h61);
        enq_busy(5'd6, 64'h62);
        idle(nl);
        chk("same_addr_nl0", 64'(nl), 64'd1);
        idle(nl);
        chk("same_addr_nl1", 64'(nl), 64'd1);
        chk("same_addr_count", 64'(wb.lq_count_o), 64'd0);

        // Long result to x0 is accepted and silently dropped.
        step(0, 0, 0, 0, 0, 0, 1, 5'd0, 64'hDEAD, 2'b00, nl);
        chk("x0_long_nl", 64'(nl), 64'd0);
        idle(nl);
        chk("x0_long_nl1", 64'(nl), 64'd0);
        chk("x0_long_count", 64'(wb.lq_count_o), 64'd0);

        // Back-to-back long results with idle pipes: pointers wrap repeatedly.
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 5'(16 + i), 64'($urandom), 2'b00, nl);
            chk("b2b_nl", 64'(nl), (i == 0 && !BYP) ? 64'd0 : 64'd1);
            chk("b2b_cnt_le1", 64'(wb.lq_count_o <= 1), 64'd1);
            chk("b2b_ready", 64'(wb.long_ready_o), 64'd1);
        end
        idle(nl);
        chk("b2b_tail_nl", 64'(nl), BYP ? 64'd0 : 64'd1);
        chk("b2b_empty", 64'(lq_exp.size()), 64'd0);
        chk("b2b_count", 64'(wb.lq_count_o), 64'd0);

        // Single long result into an empty queue (same-cycle when bypass built in).
        step(0, 0, 0, 0, 0, 0, 1, 5'd2, 64'h55, 2'b00, nl);
        chk("byp_nl", 64'(nl), BYP ? 64'd1 : 64'd0);
        chk("byp_count", 64'(wb.lq_count_o), BYP ? 64'd0 : 64'd1);
        idle(nl);
        chk("byp_tail_nl", 64'(nl), BYP ? 64'd0 : 64'd1);

        // Mid-operation reset discards queued entries.
        enq_busy(5'd12, 64'hC1);
        enq_busy(5'd13, 64'hC2);
        rst_n = 1'b0;
        wb.pipe0_v_i = 1; wb.pipe0_addr_i = 5'd3; wb.pipe0_data_i = 64'hAB;
        #1;
        reset_checks("midrst");
        lq_exp.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wb.pipe0_v_i = 0;
        #1;
        chk("midrst_ready", 64'(wb.long_ready_o), 64'd1);
        idle(nl);
        chk("midrst_nl", 64'(nl), 64'd0);
        chk("midrst_count", 64'(wb.lq_count_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
